fetch_unit: RTL

//  Instruction-fetch front end for the CPU: owns the fetch PC, issues word requests to

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch queue of fetch entries. Flush wins over push
// and pop; the head entry is read combinationally from the storage array.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Next pointer/count state; flush empties the queue regardless of push/pop.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; count_q alone decides which slots are meaningful.
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word
// requests, tags returning words with their PC in a prefetch queue, and drops
// words that were already in flight when a redirect arrived.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter int                   DEPTH     = 2,
  parameter logic [DATAWIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATAWIDTH-1:0] inst_o,
  output logic [DATAWIDTH-1:0] pc_o
);

  localparam int           CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATAWIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [CW:0]   credit_used;
  logic          grant;
  logic          push;
  logic          pop;

  // Request/credit and handshake decode; a redirect suppresses request, push and pop.
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    imem_req_o  = rst_i && (credit_used < DEPTH_W) && !redirect_i;
    imem_addr_o = fetch_pc_q;
    grant       = imem_req_o && imem_gnt_i;
    valid_o     = rst_i && !fifo_empty;
    pop         = valid_o && ready_i && !redirect_i;
    push        = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    push_entry  = '{pc: resp_pc_q, inst: imem_rdata_i};
  end

  // Next PCs and in-flight/discard counters; a redirect marks every word still in flight as stale.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_i) begin
      fetch_pc_d    = word_align(redirect_pc_i);
      resp_pc_d     = word_align(redirect_pc_i);
      outstanding_d = outstanding_q - CW'(imem_rvalid_i);
      discard_d     = outstanding_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + DATAWIDTH'(INST_BYTES);
      if (push)  resp_pc_d  = resp_pc_q + DATAWIDTH'(INST_BYTES);
      outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
      if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  // PC and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q    <= BOOT_ADDR;
      resp_pc_q     <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign inst_o = fifo_head.inst;
  assign pc_o   = fifo_head.pc;

  // The credit rule keeps queued plus in-flight words within DEPTH, so these must hold.
  ast_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push && fifo_full && !pop));
  ast_rvalid_has_outstanding : assert property (@(posedge clk_i) disable iff (!rst_i)
    imem_rvalid_i |-> (outstanding_q != '0));
  ast_discard_bounded : assert property (@(posedge clk_i) disable iff (!rst_i)
    discard_q <= outstanding_q);

endmodule
